vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
// - Display-side consumer of VRAM. The CPU bus writes VRAM bytes at 0xF000_xxxx through the
//   CPU port; this block reads them back on the dual-port VRAM's second port.
// - Generates 640x480@60 VGA timing and scans the snake game's cell grid.
// - Each VRAM byte is one grid cell, coloured as RGB332.
// PARAMETERS
// - CLK_DIV     2    clk cycles per pixel; must be >=2 (hides the 1-cycle VRAM read latency)
// - H_VISIBLE 640 / H_FP 16 / H_SYNC 96 / H_BP 48    horizontal timing, in pixels
// - V_VISIBLE 480 / V_FP 10 / V_SYNC 2  / V_BP 33    vertical timing, in lines
// - CELL_SHIFT  4    cell is 2^CELL_SHIFT pixels square (16 -> 40x30 cell grid)
// PORTS
// - clk            in   1   system clock
// - rst_n          in   1   asynchronous active-low reset
// - vram_data      in   8   VRAM read data; valid 1 clk after vram_rd_addr changes
// - vram_rd_addr   out  16  VRAM read address = {5'b0, cell_row[4:0], cell_col[5:0]}
// - hsync          out  1   horizontal sync, active low
// - vsync          out  1   vertical sync, active low
// - red            out  3   pixel red   (cell byte [7:5])
// - green          out  3   pixel green (cell byte [4:2])
// - blue           out  2   pixel blue  (cell byte [1:0])
// - frame_start    out  1   1-clk pulse when the vertical counter enters line V_VISIBLE (vblank start)
// BEHAVIOUR
// Reset
// - All counters 0; hsync=1, vsync=1; red/green/blue=0; vram_rd_addr=0; frame_start=0.
// - Reset asserted mid-frame aborts the frame immediately.
// - After release, scan restarts at h=0, v=0 on the first pixel tick.
// Clocking and counters
// - Divider counts 0..CLK_DIV-1; the pixel tick (pix_en) fires when it is 0.
// - h_cnt (10b) counts 0..H_TOTAL-1 on pix_en; H_TOTAL=800.
// - At H_TOTAL-1: h_cnt->0 and v_cnt increments.
// - v_cnt (10b) counts 0..V_TOTAL-1; V_TOTAL=525. At the end of line V_TOTAL-1: v_cnt->0.
// Address and pipeline (stage 0 -> stage 1)
// - Stage 0, pix_en with counters (h,v): register
//   vram_rd_addr = {5'b0, v[8:4], h[9:4]} (CELL_SHIFT=4).
//   Also register visible = (h<H_VISIBLE && v<V_VISIBLE).
//   Also register the raw sync levels.
// - Stage 1, next pix_en:
//   - {red,green,blue} <= visible ? vram_data : 0
//   - hsync <= delayed hs
//   - vsync <= delayed vs
// - Fixed latency: outputs lag the counters by exactly 1 pixel tick. Sync and colour stay aligned.
// Sync timing
// - hs raw low for H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, i.e. h in 656..751.
// - vs raw low for v in 490..491.
// Blanking
// - RGB is forced to 0 for every non-visible pixel, regardless of vram_data.
// - The address still updates during blanking; reads there are don't-care.
// frame_start
// - Asserted for one clk on the pix_en where v_cnt transitions 479->480.
// - Gives the CPU a safe VRAM-update window.
// Outputs
// - Change only on pix_en cycles; held between ticks.
// CONFIGURATION
// - VGA_BORDER_EN defined:
//   - Visible pixels with h==0, h==639, v==0 or v==479 output 8'hFF (white), overriding VRAM.
//   - Border colour registered in stage 1, same latency.
// - VGA_BORDER_EN undefined:
//   - All visible pixels come from VRAM; no border logic is synthesised.
// TESTING
// - Reset release:
//   - hsync=vsync=1, rgb=0, vram_rd_addr=0 until the first pix_en.
//   - hsync falls exactly (656+1)*2 clks after the first tick.
// - Line/frame period (CLK_DIV=2):
//   - hsync period 1600 clks, low width 192 clks.
//   - vsync period 840000 clks, low for 2 lines (3200 clks).
// - Address map: counters h=17, v=33 -> vram_rd_addr=16'h0081 (row 2, col 1).
//   h=639, v=479 -> 16'h0767.
// - Colour path:
//   - VRAM cell 0 = 8'hE0 -> first visible pixel red=7, green=0, blue=0, one tick after h=0.
//   - h=640 -> rgb=0.
// - frame_start: exactly one 1-clk pulse per frame, coincident with v_cnt becoming 480.
//   Reset pulsed at v=200 -> no pulse until v reaches 480 of the new frame.
// - VGA_BORDER_EN:
//   - VRAM all 8'h00 -> pixels (0,0), (639,240), (320,479) are 8'hFF; pixel (1,1) is 0.
//   - Without the macro, all four pixels are 0.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator that scans the snake-game cell grid
// out of dual-port VRAM (one byte per cell, RGB332).
// Optional feature macro: VGA_BORDER_EN -- forces a 1-pixel white frame around the
// visible area; when undefined no border logic exists.

module vga_scanout #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CELL_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vram_data,
  output logic [15:0] vram_rd_addr,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_start
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             pix_en_c;
  logic             visible_c;
  logic             hs_raw_c;
  logic             vs_raw_c;
  logic             frame_edge_c;
  logic [4:0]       row_c;
  logic [5:0]       col_c;
  logic             visible_q;
  logic             hs_q;
  logic             vs_q;
  logic [7:0]       pix_c;

  assign pix_en_c     = (div_cnt == '0);
  assign visible_c    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw_c     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw_c     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign frame_edge_c = pix_en_c && (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
  assign row_c        = 5'(v_cnt >> CELL_SHIFT);
  assign col_c        = 6'(h_cnt >> CELL_SHIFT);

  // Pixel-clock divider: pix_en fires when the divider sits at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters: h wraps at the line end and advances v, v wraps at the frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en_c) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 0: issue the cell read and capture the per-pixel attributes that travel with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_rd_addr <= '0;
      visible_q    <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else if (pix_en_c) begin
      vram_rd_addr <= {5'b0, row_c, col_c};
      visible_q    <= visible_c;
      hs_q         <= hs_raw_c;
      vs_q         <= vs_raw_c;
    end
  end

`ifdef VGA_BORDER_EN
  logic border_c;
  logic border_q;

  assign border_c = (h_cnt == '0) || (h_cnt == H_VIS - CNT_W'(1)) ||
                    (v_cnt == '0) || (v_cnt == V_VIS_LAST);

  // Border flag rides alongside the read so the white frame keeps the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_q <= 1'b0;
    end else if (pix_en_c) begin
      border_q <= border_c;
    end
  end

  assign pix_c = visible_q ? (border_q ? 8'hFF : vram_data) : 8'h00;
`else
  assign pix_c = visible_q ? vram_data : 8'h00;
`endif

  // Stage 1: colour and sync leave together, one pixel tick behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en_c) begin
      {red, green, blue} <= pix_c;
      hsync              <= hs_q;
      vsync              <= vs_q;
    end
  end

  // One-clock pulse as the raster enters vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge_c;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench. A small-raster instance is checked every clock
// against a position-based reference model; a full-timing instance checks real VGA
// hsync placement and period.

module tb_vga_scanout;

  localparam int SH_VIS = 40, SH_FP = 2, SH_SYNC = 4, SH_BP = 2;
  localparam int SV_VIS = 48, SV_FP = 2, SV_SYNC = 2, SV_BP = 2;
  localparam int SHT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int SVT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
  localparam int DIV = 2;
  localparam int FRAME_CLK = SHT * SVT * DIV;
  localparam int FS_POS = (SV_VIS - 1) * SHT + (SHT - 1);
  localparam int FS_C = FS_POS * DIV;

  typedef struct packed {
    logic [15:0] addr;
    logic        hs;
    logic        vs;
    logic [7:0]  rgb;
    logic        fs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vram_data;
  logic [15:0] vram_rd_addr;
  logic        hsync, vsync, frame_start;
  logic [2:0]  red, green;
  logic [1:0]  blue;

  logic [7:0]  full_vram;
  logic [15:0] full_addr;
  logic        full_hs, full_vs, full_fs;
  logic [2:0]  full_r, full_g;
  logic [1:0]  full_b;

  logic [7:0]  mem [0:65535];
  exp_t        q [$];
  int          c_run;
  int          errors;
  int          checks;
  int          fs_count;
  bit          meas_on;
  logic        full_hs_prev;
  int          hs_falls, hs_rises;
  int          first_fall;

  vga_scanout #(
    .CLK_DIV(DIV), .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .CELL_SHIFT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vram_data(vram_data), .vram_rd_addr(vram_rd_addr),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  vga_scanout dut_full (
    .clk(clk), .rst_n(rst_n), .vram_data(full_vram), .vram_rd_addr(full_addr),
    .hsync(full_hs), .vsync(full_vs), .red(full_r), .green(full_g), .blue(full_b),
    .frame_start(full_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous VRAM read port: data one clock after the address.
  always @(posedge clk) vram_data <= mem[vram_rd_addr];

  function automatic int hpos(int n);
    return n % SHT;
  endfunction

  function automatic int vpos(int n);
    return (n / SHT) % SVT;
  endfunction

  function automatic logic [15:0] cell_addr(int n);
    return 16'(((vpos(n) / 16) % 32) * 64 + (hpos(n) / 16) % 64);
  endfunction

  // Expected outputs in the clock after the c-th rising edge since reset release.
  function automatic exp_t expect_cycle(int c);
    exp_t e;
    int   n, p, h, v;
    bit   vis, brd;
    n = c / DIV;
    e.addr = cell_addr(n);
    e.fs = (c % DIV == 0) && (hpos(n) == SHT - 1) && (vpos(n) == SV_VIS - 1);
    if (n == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.rgb = 8'h00;
    end else begin
      p = n - 1; h = hpos(p); v = vpos(p);
      e.hs = !(h >= SH_VIS + SH_FP && h < SH_VIS + SH_FP + SH_SYNC);
      e.vs = !(v >= SV_VIS + SV_FP && v < SV_VIS + SV_FP + SV_SYNC);
      vis = (h < SH_VIS) && (v < SV_VIS);
      brd = (h == 0) || (h == SH_VIS - 1) || (v == 0) || (v == SV_VIS - 1);
`ifdef VGA_BORDER_EN
      e.rgb = !vis ? 8'h00 : (brd ? 8'hFF : mem[cell_addr(p)]);
`else
      e.rgb = !vis ? 8'h00 : mem[cell_addr(p)];
      brd = 1'b0;
`endif
      if (brd && !vis) e.rgb = 8'h00;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: push the expected response for every clock of the scan.
  always @(posedge clk) begin
    if (!rst_n) begin
      c_run = -1;
    end else begin
      c_run = c_run + 1;
      q.push_back(expect_cycle(c_run));
    end
  end

  // Monitor: pop and compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      check("reset_small", {vram_rd_addr, hsync, vsync, red, green, blue, frame_start},
            {16'h0000, 1'b1, 1'b1, 8'h00, 1'b0});
      check("reset_full", {full_addr, full_hs, full_vs, full_r, full_g, full_b, full_fs},
            {16'h0000, 1'b1, 1'b1, 8'h00, 1'b0});
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("scan", {vram_rd_addr, hsync, vsync, red, green, blue, frame_start}, e);
      if (frame_start) fs_count++;
`ifndef VGA_BORDER_EN
      check("full_rgb_black", {24'h0, full_r, full_g, full_b}, 32'h0);
`endif
      if (meas_on && full_hs_prev && !full_hs) begin
        hs_falls++;
        if (hs_falls == 1) begin
          first_fall = c_run;
          check("hsync_first_fall_clks", c_run, (656 + 1) * 2);
        end else if (hs_falls == 2) begin
          check("hsync_period_clks", c_run - first_fall, 1600);
        end
      end
      if (meas_on && !full_hs_prev && full_hs) begin
        hs_rises++;
        if (hs_rises == 1) check("hsync_low_width_clks", c_run - first_fall, 192);
      end
      full_hs_prev = full_hs;
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
  endtask

  initial begin
    int exp_fs;
    errors = 0; checks = 0; fs_count = 0; c_run = -1;
    meas_on = 1'b0; full_hs_prev = 1'b1; hs_falls = 0; hs_rises = 0; first_fall = 0;
    full_vram = 8'h00;
    rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    repeat (3) @(negedge clk);

    // Phase 1: two full small frames with random VRAM; full instance measures hsync.
    meas_on = 1'b1;
    release_reset();
    repeat (2 * FRAME_CLK + 200) @(negedge clk);
    meas_on = 1'b0;
    check("hsync_falls_seen", 32'(hs_falls >= 2), 32'd1);
    check("hsync_rises_seen", 32'(hs_rises >= 1), 32'd1);
    exp_fs = (c_run >= FS_C) ? ((c_run - FS_C) / FRAME_CLK) + 1 : 0;
    check("frame_start_count", fs_count, exp_fs);

    // Phase 2: reset pulsed mid-frame (v=20) aborts the scan at once.
    assert_reset();
    repeat (2) @(negedge clk);
    release_reset();
    repeat (DIV * (20 * SHT + 7)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_abort", {vram_rd_addr, hsync, vsync, red, green, blue, frame_start},
          {16'h0000, 1'b1, 1'b1, 8'h00, 1'b0});
    repeat (3) @(negedge clk);
    fs_count = 0;
    release_reset();
    repeat (FS_C - 4) @(negedge clk);
    check("no_frame_start_early", fs_count, 0);
    repeat (10) @(negedge clk);
    check("frame_start_after_restart", fs_count, 1);

    // Phase 3: all-zero VRAM, one frame; only a border (if built in) may light up.
    assert_reset();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    release_reset();
    repeat (FRAME_CLK + 20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
